// File: rtl/lock_pkg.sv
// lock_pkg: shared types and defaults for the code-lock supervisor.
//   lock_state_e   - 2-bit supervisor state (IDLE/OPEN/LOCKOUT/ALARM)
//   DEF_*          - default parameter values for lock_supervisor
//   state_code()   - state_o / LED encoding of a state
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2,
        ST_ALARM   = 2'd3
    } lock_state_e;

    localparam int DEF_MAX_FAIL      = 3;
    localparam int DEF_OPEN_TICKS    = 10;
    localparam int DEF_LOCKOUT_TICKS = 30;
    localparam int DEF_TICK_W        = 8;

    // Encoding shared by the debug port and the status-LED decoder.
    function automatic logic [1:0] state_code(input lock_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/lock_supervisor_if.sv
// lock_supervisor_if: link between the code-entry/compare block and the
// supervisor.
//   attempt_done - one-cycle pulse from the entry block: an entry was compared
//   attempt_ok   - compare result, meaningful only while attempt_done=1
//   key_en       - from the supervisor: 1 = entry block may accept keypad strobes
//
// Handshake: key_en acts as "ready" and attempt_done as "valid". An attempt is
// consumed only on a cycle where attempt_done=1 and key_en=1; a pulse seen
// while key_en=0 is discarded, never queued. key_en falls on the same edge
// that door_open or locked_out rises.
// Modports: master = entry block, slave = lock_supervisor.
interface lock_supervisor_if;
    logic attempt_done;
    logic attempt_ok;
    logic key_en;

    modport master (output attempt_done, output attempt_ok, input key_en);
    modport slave  (input attempt_done, input attempt_ok, output key_en);
endinterface

// File: rtl/lock_tick_timer.sv
// lock_tick_timer: loadable down-counter on a tick time base.
//   clk, rst    - clock, synchronous active-high reset (count -> 0)
//   load_i      - load load_val_i this cycle (has priority over counting)
//   load_val_i  - value to load
//   en_i        - counting enabled (owner state is timing)
//   tick_i      - one-cycle time-base pulse; decrements when enabled
//   zero_o      - counter is 0 after this cycle's decrement (load ignored)
module lock_tick_timer #(
    parameter int TICK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic              tick_i,
    output logic              zero_o
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && tick_i && (count_q != '0)) begin
            // Saturates at 0: never wraps.
            count_d = count_q - TICK_W'(1);
        end
    end

    // Post-decrement zero: true on the cycle the count goes 1 -> 0. Computed
    // from count_q only so the owner FSM sees no path through its own load.
    assign zero_o = (count_q == '0) ||
                    (en_i && tick_i && (count_q == TICK_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lock_supervisor.sv
// lock_supervisor: sequencing controller for the six-digit code lock.
// Consumes attempt results, opens the door on success, and imposes a timed
// keypad lockout after MAX_FAIL consecutive failures.
//   clk, rst     - clock, synchronous active-high reset
//   tick         - one-cycle time-base pulse
//   relock_req   - level, manual "lock now" (also supervisor reset key in ALARM)
//   ent          - lock_supervisor_if.slave: attempt_done/attempt_ok in, key_en out
//   door_open    - lock actuator released
//   locked_out   - lockout LED (also lit in ALARM)
//   fail_cnt     - consecutive-failure count, saturating at MAX_FAIL
//   state_o      - encoded state: 0 IDLE, 1 OPEN, 2 LOCKOUT, 3 ALARM
//   alarm        - alarm output
// Build option: LOCK_ALARM_EN -- reaching MAX_FAIL enters ALARM (held until
// relock_req, then LOCKOUT) instead of going straight to LOCKOUT. Without it,
// ALARM is unreachable and alarm stays 0.
// All outputs are registered from the next-state values, so they change on
// the same edge as the state.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int MAX_FAIL      = DEF_MAX_FAIL,
    parameter int OPEN_TICKS    = DEF_OPEN_TICKS,
    parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
    parameter int TICK_W        = DEF_TICK_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     relock_req,
    lock_supervisor_if.slave         ent,
    output logic                     door_open,
    output logic                     locked_out,
    output logic [3:0]               fail_cnt,
    output logic [1:0]               state_o,
    output logic                     alarm
);

    localparam logic [3:0]        MAX_FAIL_C   = 4'(MAX_FAIL);
    localparam logic [TICK_W-1:0] OPEN_LD      = TICK_W'(OPEN_TICKS);
    localparam logic [TICK_W-1:0] LOCKOUT_LD   = TICK_W'(LOCKOUT_TICKS);

    lock_state_e       state_q, state_d;
    logic [3:0]        fail_cnt_q, fail_cnt_d;
    logic              key_en_q, door_open_q, locked_out_q, alarm_q;
    logic [1:0]        state_code_q;
    logic              alarm_d;

    logic              tmr_load;
    logic [TICK_W-1:0] tmr_load_val;
    logic              tmr_en;
    logic              tmr_zero;

    // OPEN and LOCKOUT never overlap, so one counter serves both.
    assign tmr_en = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

    lock_tick_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .tick_i     (tick),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        fail_cnt_d   = fail_cnt_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                // tick has no effect here; only attempts move the FSM.
                if (ent.attempt_done) begin
                    if (ent.attempt_ok) begin
                        fail_cnt_d   = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = OPEN_LD;
                        state_d      = ST_OPEN;
                    end else if ((fail_cnt_q + 4'd1) >= MAX_FAIL_C) begin
                        fail_cnt_d   = MAX_FAIL_C;
                        tmr_load     = 1'b1;
                        tmr_load_val = LOCKOUT_LD;
`ifdef LOCK_ALARM_EN
                        state_d      = ST_ALARM;
`else
                        state_d      = ST_LOCKOUT;
`endif
                    end else begin
                        fail_cnt_d   = fail_cnt_q + 4'd1;
                    end
                end
            end
            ST_OPEN: begin
                // Relock and expiry on the same cycle give one plain exit.
                if (relock_req || tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    fail_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_ALARM: begin
`ifdef LOCK_ALARM_EN
                if (relock_req) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = LOCKOUT_LD;
                    state_d      = ST_LOCKOUT;
                end
`else
                // Unreachable in this build; fall back to a safe state.
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LOCK_ALARM_EN
    assign alarm_d = (state_d == ST_ALARM);
`else
    assign alarm_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fail_cnt_q   <= '0;
            key_en_q     <= 1'b1;
            door_open_q  <= 1'b0;
            locked_out_q <= 1'b0;
            alarm_q      <= 1'b0;
            state_code_q <= state_code(ST_IDLE);
        end else begin
            state_q      <= state_d;
            fail_cnt_q   <= fail_cnt_d;
            key_en_q     <= (state_d == ST_IDLE);
            door_open_q  <= (state_d == ST_OPEN);
            locked_out_q <= (state_d == ST_LOCKOUT) || (state_d == ST_ALARM);
            alarm_q      <= alarm_d;
            state_code_q <= state_code(state_d);
        end
    end

    assign ent.key_en = key_en_q;
    assign door_open  = door_open_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;
    assign state_o    = state_code_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor: self-checking bench for lock_supervisor.
// Every cycle's expected outputs are pushed to exp_q when the inputs are
// driven and popped/compared #1 after the clock edge that consumes them.
module tb_lock_supervisor;
    localparam int MAX_FAIL      = 3;
    localparam int OPEN_TICKS    = 10;
    localparam int LOCKOUT_TICKS = 30;
    localparam int TICK_W        = 8;
    localparam int W             = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       relock_req;
    logic       door_open;
    logic       locked_out;
    logic [3:0] fail_cnt;
    logic [1:0] state_o;
    logic       alarm;

    lock_supervisor_if ent();

    lock_supervisor #(
        .MAX_FAIL      (MAX_FAIL),
        .OPEN_TICKS    (OPEN_TICKS),
        .LOCKOUT_TICKS (LOCKOUT_TICKS),
        .TICK_W        (TICK_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .relock_req (relock_req),
        .ent        (ent.slave),
        .door_open  (door_open),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .state_o    (state_o),
        .alarm      (alarm)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         r, t, dn, ok, rl;
        logic [W-1:0] e;
    } vec_t;
    vec_t tbl[$];

    // {key_en, door_open, locked_out, alarm, fail_cnt, state_o}
    function automatic logic [W-1:0] pk(input logic k, input logic d, input logic l,
                                        input logic a, input logic [3:0] f,
                                        input logic [1:0] s);
        return {k, d, l, a, f, s};
    endfunction
    function automatic logic [W-1:0] e_idle(input int f);
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 4'(f), 2'd0);
    endfunction
    function automatic logic [W-1:0] e_open();
        return pk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1);
    endfunction
    function automatic logic [W-1:0] e_lock();
        return pk(1'b0, 1'b0, 1'b1, 1'b0, 4'(MAX_FAIL), 2'd2);
    endfunction
    function automatic logic [W-1:0] e_alarm();
        return pk(1'b0, 1'b0, 1'b1, 1'b1, 4'(MAX_FAIL), 2'd3);
    endfunction

    task automatic check(input string nm);
        logic [W-1:0] act;
        logic [W-1:0] e;
        act = {ent.key_en, door_open, locked_out, alarm, fail_cnt, state_o};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got key=%b door=%b lo=%b al=%b fc=%0d st=%0d, want key=%b door=%b lo=%b al=%b fc=%0d st=%0d",
                         nm, act[9], act[8], act[7], act[6], act[5:2], act[1:0],
                         e[9], e[8], e[7], e[6], e[5:2], e[1:0]);
            end
        end
    endtask

    // driver: one clock cycle of inputs, then check the outputs of that edge
    task automatic cyc(input logic r, input logic t, input logic dn, input logic ok,
                       input logic rl, input logic [W-1:0] e, input string nm);
        rst               = r;
        tick              = t;
        ent.attempt_done  = dn;
        ent.attempt_ok    = ok;
        relock_req        = rl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    // n ticks separated by random idle gaps; last tick expects 'last'
    task automatic tick_run(input int n, input logic [W-1:0] during,
                            input logic [W-1:0] last, input string nm);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, 0, during, {nm, "_gap"});
            cyc(0, 1, 0, 0, 0, (i == n - 1) ? last : during, nm);
        end
    endtask

    function automatic void add(input logic r, input logic t, input logic dn,
                                input logic ok, input logic rl, input logic [W-1:0] e);
        vec_t v;
        v.r = r; v.t = t; v.dn = dn; v.ok = ok; v.rl = rl; v.e = e;
        tbl.push_back(v);
    endfunction

    // MAX_FAIL failures from fail_cnt=0 ending in LOCKOUT (via ALARM if built)
    task automatic enter_lock(input string nm);
        for (int i = 1; i < MAX_FAIL; i++) cyc(0, 0, 1, 0, 0, e_idle(i), {nm, "_fail"});
`ifdef LOCK_ALARM_EN
        cyc(0, 0, 1, 0, 0, e_alarm(), {nm, "_to_alarm"});
        tick_run(105, e_alarm(), e_alarm(), {nm, "_alarm_hold"});
        cyc(0, 0, 1, 1, 0, e_alarm(), {nm, "_alarm_ign_attempt"});
        cyc(0, 0, 0, 0, 1, e_lock(), {nm, "_alarm_relock"});
`else
        cyc(0, 0, 1, 0, 0, e_lock(), {nm, "_to_lockout"});
`endif
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; relock_req = 1'b0;
        ent.attempt_done = 1'b0; ent.attempt_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // table: reset, failures, success, relock, full open timeout
        add(1, 0, 0, 0, 0, e_idle(0));   // reset
        add(0, 0, 0, 0, 0, e_idle(0));
        add(0, 0, 1, 0, 0, e_idle(1));   // fail 1
        add(0, 1, 0, 0, 0, e_idle(1));   // tick ignored in IDLE
        add(0, 0, 1, 0, 0, e_idle(2));   // fail 2
        add(0, 1, 1, 1, 0, e_open());    // success with tick: processed
        add(0, 0, 1, 0, 0, e_open());    // attempt ignored in OPEN
        add(0, 0, 0, 0, 1, e_idle(0));   // manual relock
        add(0, 0, 1, 1, 0, e_open());
        for (int i = 1; i < OPEN_TICKS; i++) add(0, 1, 0, 0, 0, e_open());
        add(0, 1, 0, 0, 0, e_idle(0));   // 10th tick closes
        add(0, 0, 1, 1, 0, e_open());
        for (int i = 1; i < OPEN_TICKS; i++) add(0, 1, 0, 0, 0, e_open());
        add(0, 1, 0, 0, 1, e_idle(0));   // final tick + relock together
        add(0, 1, 0, 0, 0, e_idle(0));   // no second transition

        foreach (tbl[i]) cyc(tbl[i].r, tbl[i].t, tbl[i].dn, tbl[i].ok, tbl[i].rl,
                             tbl[i].e, $sformatf("tbl%0d", i));

        // lockout: ignored inputs, then expiry on the 30th tick
        enter_lock("lk");
        cyc(0, 0, 1, 1, 0, e_lock(), "lk_ign_attempt");
        cyc(0, 0, 0, 0, 1, e_lock(), "lk_ign_relock");
        tick_run(LOCKOUT_TICKS, e_lock(), e_idle(0), "lk_tick");
        cyc(0, 0, 0, 0, 0, e_idle(0), "lk_after");

        // reset mid-lockout with timer at 12
        enter_lock("rs");
        tick_run(LOCKOUT_TICKS - 12, e_lock(), e_lock(), "rs_tick");
        cyc(1, 0, 0, 0, 0, e_idle(0), "rs_reset");
        cyc(0, 1, 0, 0, 0, e_idle(0), "rs_after");
        cyc(0, 0, 1, 0, 0, e_idle(1), "rs_fresh_fail");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Sequencing controller for the six-digit code lock. It sits downstream of the code-entry/compare block and consumes one "attempt finished" pulse with a pass/fail flag per entry. From these it decides when the door is open, when keypad entry is allowed, and when to impose a timed lockout after repeated failures. It also drives the status LEDs and gates the keypad strobe back into the entry block.

## Interface
Parameters:
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (range 1..15).
- OPEN_TICKS, 10: ticks the lock stays open before automatic relock.
- LOCKOUT_TICKS, 30: ticks of keypad lockout.
- TICK_W, 8: width of the tick down-counter; must hold max(OPEN_TICKS, LOCKOUT_TICKS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- tick  in  1  one-cycle time-base pulse (e.g. 1 Hz), synchronous to clk.
- attempt_done  in  1  one-cycle pulse: a six-digit entry has been compared.
- attempt_ok  in  1  compare result; sampled only when attempt_done=1.
- relock_req  in  1  level; manual "lock now" button, already debounced.
- key_en  out  1  1 = entry block may accept keypad strobes.
- door_open  out  1  1 = lock actuator released.
- locked_out  out  1  1 = lockout active (LED).
- fail_cnt  out  4  current consecutive-failure count.
- state_o  out  2  encoded state for debug/LED: 0 IDLE, 1 OPEN, 2 LOCKOUT, 3 ALARM.
- alarm  out  1  alarm output (constant 0 unless LOCK_ALARM_EN).

## Operation
- Reset (rst=1 at a clk edge): state IDLE, fail_cnt 0, timer 0, key_en 1, door_open 0, locked_out 0, alarm 0. Reset mid-OPEN or mid-LOCKOUT aborts immediately; no state is retained.
- IDLE: key_en=1. On attempt_done:
  - attempt_ok=1: fail_cnt←0, timer←OPEN_TICKS, go to OPEN.
  - attempt_ok=0: fail_cnt←fail_cnt+1. If the new value equals MAX_FAIL: timer←LOCKOUT_TICKS, go to LOCKOUT (or ALARM, see Configuration). Otherwise stay in IDLE.
- OPEN: door_open=1, key_en=0. On each tick, timer decrements. Leave for IDLE when the timer reaches 0 or relock_req=1. If both happen in the same cycle, the result is IDLE; relock_req has no additional effect. attempt_done arriving in OPEN is ignored.
- LOCKOUT: locked_out=1, key_en=0. On each tick, timer decrements. At 0: go to IDLE with fail_cnt←0. relock_req and attempt_done are ignored.
- Timer arithmetic: unsigned TICK_W bits. Decrement occurs only on tick and never wraps below 0. The exit check uses the post-decrement value, so exit happens in the cycle the timer transitions 1→0.
- fail_cnt saturates at MAX_FAIL and is cleared only by a success, by lockout expiry, or by rst.
- Outputs are registered and are decoded from the next-state/timer registers, so they change on the same edge as the state.

## Timing
- attempt_done sampled at edge N → new state and outputs visible after edge N (one-cycle latency).
- tick and attempt_done in the same cycle while in IDLE: the attempt is processed; tick has no effect in IDLE.
- Open duration is between OPEN_TICKS−1 and OPEN_TICKS tick periods, depending on tick phase. Lockout duration is bounded the same way.
- key_en drops in the same cycle door_open or locked_out rises. Pulses the entry block issues after that cycle are discarded by this block.

## Configuration
- LOCK_ALARM_EN defined: reaching MAX_FAIL enters ALARM instead of LOCKOUT.
  - ALARM: alarm=1, locked_out=1, key_en=0.
  - Stays in ALARM until relock_req=1 (supervisor reset key), then enters LOCKOUT with timer←LOCKOUT_TICKS.
- LOCK_ALARM_EN undefined: ALARM state is unreachable, alarm is tied to 0, and state_o never reads 3.

## Structure
- Shared package lock_pkg holds:
  - state enum (IDLE/OPEN/LOCKOUT/ALARM, 2-bit);
  - default constants for MAX_FAIL, OPEN_TICKS, LOCKOUT_TICKS;
  - the state_o encoding, which the LED decoder also uses.
- One sub-module is natural: lock_tick_timer, a loadable down-counter (load, value, tick, zero flag) instantiated once. It is shared by OPEN and LOCKOUT, which are mutually exclusive.

## Test plan
- Reset, then one attempt_done with ok=1, OPEN_TICKS=10 → door_open=1 next cycle; door_open=0 on the cycle of the 10th tick; fail_cnt=0.
- Two failures then one success, MAX_FAIL=3 → fail_cnt 1, 2, then 0; state OPEN; locked_out never asserts.
- Three failures → LOCKOUT: key_en=0, locked_out=1. A fourth attempt_done is ignored. After 30 ticks → IDLE, fail_cnt=0, key_en=1.
- In OPEN, assert relock_req on the same cycle as the final tick → single transition to IDLE, door_open=0, no glitch.
- Assert rst for one cycle mid-LOCKOUT with timer at 12 → all outputs return to reset values at the next edge and key_en=1.
- With LOCK_ALARM_EN, three failures → alarm=1 persists for more than 100 ticks. relock_req → LOCKOUT with alarm=0 and timer=30.
